pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register widths, stage state encoding and helpers.
package pipe_pkg;
    localparam int ID_EX_DATA_W  = 160;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_DATA_W = 112;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 72;
    localparam int MEM_WB_CTRL_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] occ_of(stage_state_e s);
        return (s == ST_FULL) ? 2'd2 : (s == ST_HALF) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data+ctrl entry; clear kills valid and ctrl but keeps the payload.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            ctrl_q  <= ctrl_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);
    stage_state_e      state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [15:0]       stall_q, stall_d;
    logic              accept, deliver;
    logic              main_load, main_clr, skid_load, skid_clr, main_from_skid;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign in_ready = (SKID != 0) ? rdy_q : (state_q == ST_EMPTY) | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign deliver  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d   = ST_HALF;
                    main_load = 1'b1;
                end
                ST_HALF: if (deliver && accept) begin
                    main_load = 1'b1;
                end else if (deliver) begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                end else if (accept && SKID != 0) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end
                ST_FULL: if (deliver && skid_valid) begin
                    state_d        = ST_HALF;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        rdy_d   = state_d != ST_FULL;
        stall_d = (out_valid && !out_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (main_load),
        .clr_i  (main_clr),
        .data_i (main_from_skid ? skid_data : in_data),
        .ctrl_i (main_from_skid ? skid_ctrl : in_ctrl),
        .valid_o(out_valid),
        .data_o (out_data),
        .ctrl_o (out_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (skid_load),
        .clr_i  (skid_clr),
        .data_i (in_data),
        .ctrl_i (in_ctrl),
        .valid_o(skid_valid),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
    );

    assign occupancy = occ_of(state_q);
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven check of the skid stage plus directed reset, saturation and SKID=0 sequences.
module tb_pipe_stage_reg;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic [31:0] in_data0 = '0;
    logic        in_ready0, out_valid0;
    logic [31:0] out_data0;
    logic [7:0]  out_ctrl0;
    logic [1:0]  occupancy0;
    logic [15:0] stall_cnt0;

    int n_vec = 0, n_err = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .CLK(CLK), .RST(RST), .flush(1'b0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_ctrl(in_data0[7:0] ^ 8'hA5), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occupancy0), .stall_cnt(stall_cnt0)
    );

    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] d;
        logic        ev, eir;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic [15:0] es;
    } vec_t;

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] d, logic ev, logic eir,
                                logic [31:0] ed, logic [1:0] eo, logic [15:0] es);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d; v.ev = ev; v.eir = eir;
        v.ed = ed; v.eo = eo; v.es = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic iv, logic ordy, logic fl, logic [31:0] d);
        @(negedge CLK);
        in_valid = iv; out_ready = ordy; flush = fl; in_data = d; in_ctrl = d[7:0] ^ 8'hA5;
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 1, 0, i, 1, 1, i, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 'hA, 1, 1, 'hA, 1, 0));
        tbl.push_back(mk(1, 0, 0, 'hB, 1, 0, 'hA, 2, 1));
        tbl.push_back(mk(1, 0, 0, 'hD, 1, 0, 'hA, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'hA, 2, 3));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 'hB, 1, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 'h11, 1, 1, 'h11, 1, 3));
        tbl.push_back(mk(1, 0, 0, 'h12, 1, 0, 'h11, 2, 4));
        tbl.push_back(mk(1, 0, 1, 'hC, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(1, 1, 0, 'h13, 1, 1, 'h13, 1, 5));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 5));

        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_ctrl", 32'(out_ctrl), 0);
        chk("rst out_data", out_data, 0);
        chk("rst occupancy", 32'(occupancy), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst in_ready", 32'(in_ready), 1);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].d);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("v%0d out_data", i), out_data, tbl[i].ed);
            chk($sformatf("v%0d out_ctrl", i), 32'(out_ctrl), tbl[i].ev ? 32'(tbl[i].ed[7:0] ^ 8'hA5) : 0);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tbl[i].eo));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].es));
        end

        drive(1, 0, 0, 'h31);
        drive(1, 0, 0, 'h32);
        chk("pre-rst occupancy", 32'(occupancy), 2);
        @(negedge CLK);
        RST = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 'h33; out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst out_valid", 32'(out_valid), 0);
        chk("midrst out_ctrl", 32'(out_ctrl), 0);
        chk("midrst out_data", out_data, 0);
        chk("midrst occupancy", 32'(occupancy), 0);
        chk("midrst stall_cnt", 32'(stall_cnt), 0);
        @(negedge CLK);
        RST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 1);
        chk("midrst out_valid2", 32'(out_valid), 0);

        drive(1, 0, 0, 'h55);
        @(negedge CLK) in_valid = 1'b0;
        repeat (70000) @(posedge CLK);
        #1;
        chk("sat stall_cnt", 32'(stall_cnt), 'hFFFF);
        repeat (10) @(posedge CLK);
        #1;
        chk("sat hold stall_cnt", 32'(stall_cnt), 'hFFFF);
        chk("sat hold out_data", out_data, 'h55);

        begin
            logic [31:0] q[$];
            int cnt = 0;
            logic acc, del;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                in_valid0 = 1'b1; in_data0 = 32'h21 + i; out_ready0 = (i % 2 == 0);
                #1;
                chk($sformatf("s0 c%0d in_ready", i), 32'(in_ready0), 32'((cnt == 0) | out_ready0));
                chk($sformatf("s0 c%0d occupancy", i), 32'(occupancy0), 32'(cnt));
                acc = in_valid0 & ((cnt == 0) | out_ready0);
                del = (cnt != 0) & out_ready0;
                if (del) begin
                    chk($sformatf("s0 c%0d out_data", i), out_data0, q[0]);
                    chk($sformatf("s0 c%0d out_ctrl", i), 32'(out_ctrl0), 32'(q[0][7:0] ^ 8'hA5));
                    void'(q.pop_front());
                end
                if (acc) q.push_back(in_data0);
                cnt = q.size();
                @(posedge CLK);
            end
            @(negedge CLK) in_valid0 = 1'b0; out_ready0 = 1'b1;
            #1;
            chk("s0 last out_data", out_data0, q[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
